compute_clock_gate_ctrl: RTL and testbench

- Control-clock-domain FSM that produces compute_clock_en_n, the active-low enable for the glitchless compute-clock buffer.
- Starts compute execution on host command and counts enabled compute cycles against a budget.
- Gates the compute clock on cache/memory stall, host abort or core exception, and reports completion status to the host-facing control unit.

---
 rtl/compute_clock_gate_pkg.sv | 20 ++
 rtl/compute_clock_gate_ctrl_resume_timer.sv | 28 ++
 rtl/compute_clock_gate_ctrl.sv | 149 ++++++++++++++
 tb/tb_compute_clock_gate_ctrl.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/compute_clock_gate_pkg.sv
// Shared constants and types for the compute clock-gate controller.
package compute_clock_gate_pkg;

  // Width of the done_reason status field reported to the host.
  localparam int REASON_W = 2;

  // Controller states, kept as plain constants so legacy code can compare against them.
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_RUN    = 2'd1;
  localparam logic [1:0] ST_STALL  = 2'd2;
  localparam logic [1:0] ST_RESUME = 2'd3;

  // Why the most recent run ended.
  typedef enum logic [REASON_W-1:0] {
    REASON_LIMIT     = 2'd0,
    REASON_ABORT     = 2'd1,
    REASON_EXCEPTION = 2'd2
  } done_reason_e;

endpackage

// File: rtl/compute_clock_gate_ctrl_resume_timer.sv
// Loadable down-counter that paces the return from a stall back to RUN.
module resume_timer #(
  parameter int W = 2
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         load,
  input  logic         dec,
  input  logic [W-1:0] load_value,
  output logic         zero
);

  logic [W-1:0] count;

  // Load takes precedence over decrement; the count saturates at zero.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (dec && (count != '0)) begin
      count <= count - 1'b1;
    end
  end

  assign zero = (count == '0);

endmodule

// File: rtl/compute_clock_gate_ctrl.sv
// Control-domain FSM driving the active-low enable of the compute clock buffer,
// counting enabled compute cycles against a host-supplied budget.
module compute_clock_gate_ctrl
  import compute_clock_gate_pkg::*;
#(
  parameter int CNT_W        = 48,
  parameter int ID_W         = 16,
  parameter int RESUME_DELAY = 2
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                start,
  input  logic [CNT_W-1:0]    cycle_limit,
  input  logic                stop_req,
  input  logic                stall_req,
  input  logic                exception_valid,
  input  logic [ID_W-1:0]     exception_id,
  output logic                compute_clock_en_n,
  output logic                running,
  output logic                done,
  output logic [REASON_W-1:0] done_reason,
  output logic [ID_W-1:0]     exception_id_q,
  output logic [CNT_W-1:0]    cycles_executed
);

  localparam int              TMR_W       = $clog2(RESUME_DELAY + 1);
  localparam logic [TMR_W-1:0] RESUME_LOAD = TMR_W'(RESUME_DELAY - 1);

  logic [1:0]          state_q, state_d;
  logic [CNT_W-1:0]    limit_q, limit_d;
  logic [CNT_W-1:0]    cycles_d, cycles_inc;
  logic                en_n_d, running_d, done_d;
  logic [REASON_W-1:0] reason_d;
  logic [ID_W-1:0]     exc_id_d;
  logic                finish;
  done_reason_e        finish_reason;
  logic                tmr_load, tmr_dec, tmr_zero;

  assign cycles_inc = cycles_executed + CNT_W'(1);

  resume_timer #(
    .W(TMR_W)
  ) u_resume_timer (
    .clock      (clock),
    .reset_n    (reset_n),
    .load       (tmr_load),
    .dec        (tmr_dec),
    .load_value (RESUME_LOAD),
    .zero       (tmr_zero)
  );

  // Next-state decode; the enable is derived from the next state so it leaves a flop glitch-free.
  always_comb begin
    state_d       = state_q;
    limit_d       = limit_q;
    cycles_d      = cycles_executed;
    reason_d      = done_reason;
    exc_id_d      = exception_id_q;
    done_d        = 1'b0;
    finish        = 1'b0;
    finish_reason = REASON_LIMIT;
    tmr_load      = 1'b0;
    tmr_dec       = 1'b0;

    if (!compute_clock_en_n) begin
      cycles_d = cycles_inc;
    end

    if (state_q == ST_IDLE) begin
      if (start) begin
        cycles_d = '0;
        exc_id_d = '0;
        reason_d = REASON_LIMIT;
        limit_d  = cycle_limit;
        if (cycle_limit == '0) begin
          done_d = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end
    end else if (exception_valid) begin
      finish        = 1'b1;
      finish_reason = REASON_EXCEPTION;
      exc_id_d      = exception_id;
    end else if (stop_req) begin
      finish        = 1'b1;
      finish_reason = REASON_ABORT;
    end else begin
      case (state_q)
        ST_RUN: begin
          if (cycles_inc == limit_q) begin
            finish = 1'b1;
          end else if (stall_req) begin
            state_d = ST_STALL;
          end
        end
        ST_STALL: begin
          if (!stall_req) begin
            tmr_load = 1'b1;
            state_d  = ST_RESUME;
          end
        end
        ST_RESUME: begin
          if (stall_req) begin
            state_d = ST_STALL;
          end else if (tmr_zero) begin
            state_d = ST_RUN;
          end else begin
            tmr_dec = 1'b1;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    if (finish) begin
      state_d  = ST_IDLE;
      done_d   = 1'b1;
      reason_d = finish_reason;
    end

    en_n_d    = (state_d != ST_RUN);
    running_d = (state_d != ST_IDLE);
  end

  // State and output registers; reset gates the compute clock on the very next edge.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q            <= ST_IDLE;
      limit_q            <= '0;
      compute_clock_en_n <= 1'b1;
      running            <= 1'b0;
      done               <= 1'b0;
      done_reason        <= REASON_LIMIT;
      exception_id_q     <= '0;
      cycles_executed    <= '0;
    end else begin
      state_q            <= state_d;
      limit_q            <= limit_d;
      compute_clock_en_n <= en_n_d;
      running            <= running_d;
      done               <= done_d;
      done_reason        <= reason_d;
      exception_id_q     <= exc_id_d;
      cycles_executed    <= cycles_d;
    end
  end

endmodule

// File: tb/tb_compute_clock_gate_ctrl.sv
// Self-checking bench for compute_clock_gate_ctrl: table of run scenarios with a
// completion scoreboard, plus hand-written idle-exception and mid-run reset sequences.
module tb_compute_clock_gate_ctrl;

  localparam int CNT_W        = 48;
  localparam int ID_W         = 16;
  localparam int RESUME_DELAY = 2;

  logic             clock;
  logic             reset_n;
  logic             start;
  logic [CNT_W-1:0] cycle_limit;
  logic             stop_req;
  logic             stall_req;
  logic             exception_valid;
  logic [ID_W-1:0]  exception_id;
  logic             compute_clock_en_n;
  logic             running;
  logic             done;
  logic [1:0]       done_reason;
  logic [ID_W-1:0]  exception_id_q;
  logic [CNT_W-1:0] cycles_executed;

  compute_clock_gate_ctrl #(
    .CNT_W        (CNT_W),
    .ID_W         (ID_W),
    .RESUME_DELAY (RESUME_DELAY)
  ) dut (
    .clock              (clock),
    .reset_n            (reset_n),
    .start              (start),
    .cycle_limit        (cycle_limit),
    .stop_req           (stop_req),
    .stall_req          (stall_req),
    .exception_valid    (exception_valid),
    .exception_id       (exception_id),
    .compute_clock_en_n (compute_clock_en_n),
    .running            (running),
    .done               (done),
    .done_reason        (done_reason),
    .exception_id_q     (exception_id_q),
    .cycles_executed    (cycles_executed)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic [CNT_W-1:0] limit;
    int               stall_at;
    int               stall_len;
    int               exc_at;
    logic [ID_W-1:0]  exc_id;
    int               stop_at;
    bit               stop_in_stall;
    int               restart_at;
    logic [1:0]       exp_reason;
    logic [CNT_W-1:0] exp_cycles;
    logic [ID_W-1:0]  exp_exc_id;
    int               exp_gated;
    int               exp_latency;
  } vec_t;

  typedef struct packed {
    logic [1:0]       reason;
    logic [CNT_W-1:0] cycles;
    logic [ID_W-1:0]  exc_id;
  } exp_t;

  exp_t sb[$];
  vec_t vecs[9];

  int checks       = 0;
  int failures     = 0;
  int en_low_count = 0;
  int gated_count  = 0;
  int done_count   = 0;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: counts enabled/gated cycles and retires scoreboard entries on each done pulse.
  always @(negedge clock) begin
    exp_t e;
    if (!compute_clock_en_n) en_low_count++;
    if (running && compute_clock_en_n) gated_count++;
    if (done) begin
      done_count++;
      if (sb.size() == 0) begin
        checkOutput("sb_unexpected_done", 64'(done), 64'd0);
      end else begin
        e = sb.pop_front();
        checkOutput("done_reason", 64'(done_reason), 64'(e.reason));
        checkOutput("cycles_at_done", 64'(cycles_executed), 64'(e.cycles));
        checkOutput("exc_id_at_done", 64'(exception_id_q), 64'(e.exc_id));
        checkOutput("running_at_done", 64'(running), 64'd0);
        checkOutput("en_n_at_done", 64'(compute_clock_en_n), 64'd1);
      end
    end
  end

  // Drive one run scenario from start to completion and check its cycle-level behaviour.
  task automatic applyStimulus(input vec_t v);
    int  lat;
    int  stall_left;
    bit  stall_started;
    bit  stop_sent;
    stall_left    = 0;
    stall_started = 1'b0;
    stop_sent     = 1'b0;
    @(posedge clock); #1;
    cycle_limit  = v.limit;
    start        = 1'b1;
    sb.push_back('{reason: v.exp_reason, cycles: v.exp_cycles, exc_id: v.exp_exc_id});
    en_low_count = 0;
    gated_count  = 0;
    done_count   = 0;
    @(posedge clock); #1;
    lat   = 1;
    start = 1'b0;
    if (v.limit != '0) begin
      checkOutput("cycles_cleared_on_start", 64'(cycles_executed), 64'd0);
      checkOutput("running_after_start", 64'(running), 64'd1);
    end
    while (!done && lat < 2000) begin
      start           = 1'b0;
      exception_valid = 1'b0;
      stop_req        = 1'b0;
      cycle_limit     = v.limit;
      if (stall_req) begin
        if (stall_left > 0) stall_left--;
        else stall_req = 1'b0;
      end
      if (!stall_started && v.stall_at >= 0 && running && !compute_clock_en_n &&
          cycles_executed == CNT_W'(v.stall_at)) begin
        stall_req     = 1'b1;
        stall_left    = v.stall_len - 1;
        stall_started = 1'b1;
      end
      if (v.stop_in_stall && stall_started && !stop_sent && running && compute_clock_en_n) begin
        stop_req  = 1'b1;
        stop_sent = 1'b1;
      end
      if (v.stop_at >= 0 && running && !compute_clock_en_n && cycles_executed == CNT_W'(v.stop_at))
        stop_req = 1'b1;
      if (v.exc_at >= 0 && running && !compute_clock_en_n && cycles_executed == CNT_W'(v.exc_at)) begin
        exception_valid = 1'b1;
        exception_id    = v.exc_id;
      end
      if (v.restart_at >= 0 && running && !compute_clock_en_n && cycles_executed == CNT_W'(v.restart_at)) begin
        start       = 1'b1;
        cycle_limit = CNT_W'(3);
      end
      @(posedge clock); #1;
      lat++;
    end
    start           = 1'b0;
    exception_valid = 1'b0;
    stop_req        = 1'b0;
    stall_req       = 1'b0;
    checkOutput("done_within_budget", 64'(done), 64'd1);
    checkOutput("done_latency", 64'(lat), 64'(v.exp_latency));
    repeat (3) @(posedge clock);
    #1;
    checkOutput("done_pulse_count", 64'(done_count), 64'd1);
    checkOutput("enabled_cycles", 64'(en_low_count), 64'(v.exp_cycles));
    checkOutput("gated_while_running", 64'(gated_count), 64'(v.exp_gated));
  endtask

  initial begin
    int n;
    vecs[0] = '{limit: 48'd5,   stall_at: -1, stall_len: 0,  exc_at: -1, exc_id: 16'h0, stop_at: -1,
                stop_in_stall: 1'b0, restart_at: -1, exp_reason: 2'd0, exp_cycles: 48'd5,
                exp_exc_id: 16'h0, exp_gated: 0, exp_latency: 6};
    vecs[1] = '{limit: 48'd0,   stall_at: -1, stall_len: 0,  exc_at: -1, exc_id: 16'h0, stop_at: -1,
                stop_in_stall: 1'b0, restart_at: -1, exp_reason: 2'd0, exp_cycles: 48'd0,
                exp_exc_id: 16'h0, exp_gated: 0, exp_latency: 1};
    vecs[2] = '{limit: 48'd100, stall_at: 20, stall_len: 10, exc_at: -1, exc_id: 16'h0, stop_at: -1,
                stop_in_stall: 1'b0, restart_at: -1, exp_reason: 2'd0, exp_cycles: 48'd100,
                exp_exc_id: 16'h0, exp_gated: 12, exp_latency: 113};
    vecs[3] = '{limit: 48'd8,   stall_at: 7,  stall_len: 3,  exc_at: -1, exc_id: 16'h0, stop_at: -1,
                stop_in_stall: 1'b0, restart_at: -1, exp_reason: 2'd0, exp_cycles: 48'd8,
                exp_exc_id: 16'h0, exp_gated: 0, exp_latency: 9};
    vecs[4] = '{limit: 48'd10,  stall_at: -1, stall_len: 0,  exc_at: -1, exc_id: 16'h0, stop_at: -1,
                stop_in_stall: 1'b0, restart_at: 4, exp_reason: 2'd0, exp_cycles: 48'd10,
                exp_exc_id: 16'h0, exp_gated: 0, exp_latency: 11};
    vecs[5] = '{limit: 48'd20,  stall_at: -1, stall_len: 0,  exc_at: -1, exc_id: 16'h0, stop_at: 7,
                stop_in_stall: 1'b0, restart_at: -1, exp_reason: 2'd1, exp_cycles: 48'd8,
                exp_exc_id: 16'h0, exp_gated: 0, exp_latency: 9};
    vecs[6] = '{limit: 48'd50,  stall_at: 10, stall_len: 40, exc_at: -1, exc_id: 16'h0, stop_at: -1,
                stop_in_stall: 1'b1, restart_at: -1, exp_reason: 2'd1, exp_cycles: 48'd11,
                exp_exc_id: 16'h0, exp_gated: 1, exp_latency: 13};
    vecs[7] = '{limit: 48'd3,   stall_at: -1, stall_len: 0,  exc_at: -1, exc_id: 16'h0, stop_at: -1,
                stop_in_stall: 1'b0, restart_at: -1, exp_reason: 2'd0, exp_cycles: 48'd3,
                exp_exc_id: 16'h0, exp_gated: 0, exp_latency: 4};
    vecs[8] = '{limit: 48'd100, stall_at: -1, stall_len: 0,  exc_at: 30, exc_id: 16'h00AB, stop_at: -1,
                stop_in_stall: 1'b0, restart_at: -1, exp_reason: 2'd2, exp_cycles: 48'd31,
                exp_exc_id: 16'h00AB, exp_gated: 0, exp_latency: 32};

    reset_n         = 1'b0;
    start           = 1'b0;
    cycle_limit     = '0;
    stop_req        = 1'b0;
    stall_req       = 1'b0;
    exception_valid = 1'b0;
    exception_id    = '0;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("reset_en_n", 64'(compute_clock_en_n), 64'd1);
    checkOutput("reset_running", 64'(running), 64'd0);
    checkOutput("reset_done", 64'(done), 64'd0);
    checkOutput("reset_reason", 64'(done_reason), 64'd0);
    checkOutput("reset_exc_id", 64'(exception_id_q), 64'd0);
    checkOutput("reset_cycles", 64'(cycles_executed), 64'd0);
    reset_n = 1'b1;

    for (int i = 0; i < 9; i++) begin
      $display("[TB] scenario %0d limit=%0d", i, vecs[i].limit);
      applyStimulus(vecs[i]);
    end

    // Exception while idle must not disturb the id latched by the previous run.
    @(posedge clock); #1;
    exception_valid = 1'b1;
    exception_id    = 16'h1234;
    @(posedge clock); #1;
    exception_valid = 1'b0;
    @(posedge clock); #1;
    checkOutput("idle_exc_id_kept", 64'(exception_id_q), 64'h00AB);
    checkOutput("idle_exc_reason_kept", 64'(done_reason), 64'd2);
    checkOutput("idle_exc_running", 64'(running), 64'd0);

    // Reset mid-run gates the clock and clears everything on the next edge.
    cycle_limit = CNT_W'(50);
    start       = 1'b1;
    @(posedge clock); #1;
    start = 1'b0;
    n = 0;
    while (cycles_executed != CNT_W'(10) && n < 200) begin
      @(posedge clock); #1;
      n++;
    end
    checkOutput("midrun_reached", 64'(cycles_executed), 64'd10);
    reset_n = 1'b0;
    @(posedge clock); #1;
    checkOutput("midrun_reset_en_n", 64'(compute_clock_en_n), 64'd1);
    checkOutput("midrun_reset_running", 64'(running), 64'd0);
    checkOutput("midrun_reset_done", 64'(done), 64'd0);
    checkOutput("midrun_reset_reason", 64'(done_reason), 64'd0);
    checkOutput("midrun_reset_exc_id", 64'(exception_id_q), 64'd0);
    checkOutput("midrun_reset_cycles", 64'(cycles_executed), 64'd0);
    reset_n = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    checkOutput("midrun_stays_idle", 64'(running), 64'd0);
    checkOutput("sb_drained", 64'(sb.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time limit so a stuck run can never hang the simulation.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog_timeout actual=running expected=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
